// File: rtl/div4_restoring.sv
// Iterative restoring divider: one trial subtraction per cycle, borrow selects the
// quotient bit and whether the partial remainder is restored. start/busy/done handshake.
module div4_restoring #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [W-1:0]   q, q_next;
  logic [W-1:0]   d, d_next;
  logic [W:0]     r, r_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic [W-1:0]   quotient_next, remainder_next;
  logic           dbz_next;

  logic [W+1:0]   s_full;
  logic [W+1:0]   t;
  logic           borrow;
  logic [W:0]     r_step;
  logic [W-1:0]   q_step;

  // One restoring step. R[W] is always 0 (R < D), so shifting the full R
  // gives the same trial difference as shifting R[W-1:0] with a zero pad.
  always_comb begin
    s_full = {r, q[W-1]};
    t      = s_full - {2'b00, d};
    borrow = t[W+1];
    r_step = borrow ? s_full[W:0] : t[W:0];
    q_step = {q[W-2:0], ~borrow};
  end

  // Next-state and datapath update
  always_comb begin
    state_next     = state;
    q_next         = q;
    d_next         = d;
    r_next         = r;
    cnt_next       = cnt;
    quotient_next  = quotient;
    remainder_next = remainder;
    dbz_next       = div_by_zero;

    case (state)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            q_next     = dividend;
            d_next     = divisor;
            r_next     = '0;
            cnt_next   = CW'(W);
            state_next = RUN;
          end else begin
            quotient_next  = '1;
            remainder_next = dividend;
            dbz_next       = 1'b1;
            state_next     = DONE;
          end
        end
      end
      RUN: begin
        q_next   = q_step;
        r_next   = r_step;
        cnt_next = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          quotient_next  = q_step;
          remainder_next = r_step[W-1:0];
          dbz_next       = 1'b0;
          state_next     = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; busy/done are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      q           <= '0;
      d           <= '0;
      r           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      q           <= q_next;
      d           <= d_next;
      r           <= r_next;
      cnt         <= cnt_next;
      quotient    <= quotient_next;
      remainder   <= remainder_next;
      div_by_zero <= dbz_next;
      busy        <= (state_next == RUN);
      done        <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_div4_restoring.sv
// Scoreboard bench for div4_restoring: stimulus pushes expected results,
// a negedge monitor pops on done and also checks held outputs and reset values.
module tb_div4_restoring;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  always #5 clk = ~clk;

  div4_restoring #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  int   checks  = 0;
  int   errors  = 0;
  int   ops     = 0;
  int   flushed = 0;
  int   dones   = 0;
  logic rst_d   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: plain unsigned division; divide by zero gives all-ones, dividend, flag
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t m;
    if (b == '0) begin
      m.q = '1;
      m.r = a;
      m.z = 1'b1;
    end else begin
      m.q = a / b;
      m.r = a % b;
      m.z = 1'b0;
    end
    return m;
  endfunction

  always @(posedge clk) rst_d <= rst;

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_d) begin
      check("rst_quotient", 32'(quotient), 0);
      check("rst_remainder", 32'(remainder), 0);
      check("rst_dbz", 32'(div_by_zero), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      flushed += sb.size();
      sb.delete();
      held.q = '0;
      held.r = '0;
      held.z = 1'b0;
    end else if (done) begin
      dones++;
      check("done_with_busy", 32'(busy), 0);
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.z));
        held = e;
      end
    end else begin
      check("hold_quotient", 32'(quotient), 32'(held.q));
      check("hold_remainder", 32'(remainder), 32'(held.r));
      check("hold_dbz", 32'(div_by_zero), 32'(held.z));
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("issue_timeout", 1, 0);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b));
    ops++;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Waits for done after an accepted start; optionally injects starts that must be dropped
  task automatic wait_done(input logic [W-1:0] b, input bit noise, input int pulse_at);
    int lat  = 0;
    int bc   = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
      if (done) begin
        seen     = 1'b1;
        start    = noise;
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end else if (lat == pulse_at) begin
        start    = 1'b1;
        dividend = W'(1);
        divisor  = W'(1);
      end else if (noise && busy) begin
        start    = 1'($urandom_range(0, 1));
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
    end else begin
      check("latency", 32'(lat), (b == '0) ? 32'd1 : 32'(W + 1));
      check("busy_cycles", 32'(bc), (b == '0) ? 32'd0 : 32'(W));
    end
    if (start) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    issue(a, b);
    wait_done(b, noise, -1);
  endtask

  initial begin
    int d0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run_op(W'(13), W'(3), 1'b0);
    run_op(W'(15), W'(1), 1'b0);
    run_op(W'(7), W'(9), 1'b0);
    run_op(W'(9), W'(0), 1'b0);

    // start with 1/1 during RUN must be dropped
    issue(W'(12), W'(5));
    wait_done(W'(5), 1'b0, 2);

    // reset mid-operation aborts with no done
    issue(W'(12), W'(5));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    d0 = dones;
    repeat (W + 4) @(negedge clk);
    check("abort_no_done", 32'(dones), 32'(d0));
    check("abort_idle_busy", 32'(busy), 0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(W'(a), W'(b), 1'b0);

    repeat (60) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'b1);
    end

    repeat (4) @(negedge clk);
    check("done_count", 32'(dones), 32'(ops - flushed));
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
